// File: rtl/l2_cache_control.sv
// l2_cache_control: control FSM for the set-associative L2 cache.
//
// It sits between the L2 datapath (tag/valid/dirty arrays and compare logic)
// and the pseudo-LRU tree. It picks miss victims and updates the tree on hits.
// It also sequences the writeback and fill transactions with physical memory.
// Only one upstream request is in service at a time.
//
// Ports:
//   clk, rst             clock; asynchronous active-low reset
//   mem_read/mem_write   upstream request (both high = write), held until mem_resp
//   mem_resp             one-cycle completion pulse to upstream
//   hit_vec/valid_vec/dirty_vec   per-way status of the addressed set
//   lru_way              one-hot victim from the LRU tree
//   lru_load/lru_hit_way update strobe and way reported to the LRU tree
//   way_sel              one-hot way for the datapath read mux and array writes
//   data_load/data_src/tag_load/valid_set/dirty_set/dirty_clr   array strobes
//   pmem_read/pmem_write/pmem_addr_sel/pmem_resp   lower-memory handshake
//   hit_count/miss_count saturating 32-bit event counters

// Assertion checker for the illegal-input cases on the datapath and LRU tree.
module l2_cache_control_chk #(
    parameter int num_ways = 8
) (
    input logic                clk,
    input logic                rst,
    input logic                in_compare,
    input logic [num_ways-1:0] hit_vec,
    input logic [num_ways-1:0] valid_vec,
    input logic [num_ways-1:0] lru_way
);
    a_hit_onehot: assert property (@(posedge clk) disable iff (!rst)
        in_compare |-> $onehot0(hit_vec));

    // lru_way only matters when every way is valid and there is no hit.
    a_lru_onehot: assert property (@(posedge clk) disable iff (!rst)
        (in_compare && (hit_vec == {num_ways{1'b0}}) && (&valid_vec)) |-> $onehot(lru_way));
endmodule

module l2_cache_control #(
    parameter int num_ways = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    output logic                mem_resp,
    input  logic [num_ways-1:0] hit_vec,
    input  logic [num_ways-1:0] valid_vec,
    input  logic [num_ways-1:0] dirty_vec,
    input  logic [num_ways-1:0] lru_way,
    output logic                lru_load,
    output logic [num_ways-1:0] lru_hit_way,
    output logic [num_ways-1:0] way_sel,
    output logic                data_load,
    output logic                data_src,
    output logic                tag_load,
    output logic                valid_set,
    output logic                dirty_set,
    output logic                dirty_clr,
    output logic                pmem_read,
    output logic                pmem_write,
    output logic                pmem_addr_sel,
    input  logic                pmem_resp,
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count
);
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COMPARE   = 2'd1,
        ST_WRITEBACK = 2'd2,
        ST_FILL      = 2'd3
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;
    logic [num_ways-1:0] victim_r;
    logic [num_ways-1:0] victim_s;
    logic                victim_dirty_s;
    logic                hit_s;
    logic                is_write_r;
    logic                miss_pending_r;
    logic [31:0]         hit_cnt_r;
    logic [31:0]         miss_cnt_r;

    // Isolate the lowest set bit of v (v & -v).
    function automatic logic [num_ways-1:0] lowest_set(input logic [num_ways-1:0] v);
        return v & (~v + {{(num_ways-1){1'b0}}, 1'b1});
    endfunction

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : (c + 32'd1);
    endfunction

    assign hit_s          = |hit_vec;
    // Prefer filling an empty way; only evict via the LRU tree when the set is full.
    // lru_way is sampled here, in a cycle where lru_load is low.
    assign victim_s       = (&valid_vec) ? lru_way : lowest_set(~valid_vec);
    assign victim_dirty_s = |(victim_s & valid_vec & dirty_vec);
    assign hit_count      = hit_cnt_r;
    assign miss_count     = miss_cnt_r;

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Victim latch, request type, miss bookkeeping and event counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            victim_r       <= {num_ways{1'b0}};
            is_write_r     <= 1'b0;
            miss_pending_r <= 1'b0;
            hit_cnt_r      <= 32'd0;
            miss_cnt_r     <= 32'd0;
        end else begin
            if ((state_r == ST_IDLE) && (mem_read || mem_write)) begin
                // Latch the request type so later changes on the inputs during a miss are ignored.
                is_write_r <= mem_write;
            end
            if (state_r == ST_COMPARE) begin
                if (hit_s) begin
                    hit_cnt_r      <= sat_inc(hit_cnt_r);
                    miss_pending_r <= 1'b0;
                end else begin
                    victim_r       <= victim_s;
                    miss_pending_r <= 1'b1;
                    if (!miss_pending_r) begin
                        miss_cnt_r <= sat_inc(miss_cnt_r);
                    end
                end
            end
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_nxt_s   = state_r;
        mem_resp      = 1'b0;
        lru_load      = 1'b0;
        lru_hit_way   = {num_ways{1'b0}};
        way_sel       = {num_ways{1'b0}};
        data_load     = 1'b0;
        data_src      = 1'b0;
        tag_load      = 1'b0;
        valid_set     = 1'b0;
        dirty_set     = 1'b0;
        dirty_clr     = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;
        pmem_addr_sel = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_read || mem_write) begin
                    state_nxt_s = ST_COMPARE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COMPARE: begin
                if (hit_s) begin
                    way_sel     = hit_vec;
                    lru_load    = 1'b1;
                    lru_hit_way = hit_vec;
                    mem_resp    = 1'b1;
                    if (is_write_r) begin
                        data_load = 1'b1;
                        dirty_set = 1'b1;
                    end else begin
                        data_load = 1'b0;
                        dirty_set = 1'b0;
                    end
                    state_nxt_s = ST_IDLE;
                end else if (victim_dirty_s) begin
                    state_nxt_s = ST_WRITEBACK;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            ST_WRITEBACK: begin
                way_sel       = victim_r;
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                if (pmem_resp) begin
                    state_nxt_s = ST_FILL;
                end else begin
                    state_nxt_s = ST_WRITEBACK;
                end
            end
            ST_FILL: begin
                way_sel   = victim_r;
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_load   = 1'b1;
                    data_src    = 1'b1;
                    tag_load    = 1'b1;
                    valid_set   = 1'b1;
                    dirty_clr   = 1'b1;
                    state_nxt_s = ST_COMPARE;
                end else begin
                    state_nxt_s = ST_FILL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    l2_cache_control_chk #(.num_ways(num_ways)) u_chk (
        .clk        (clk),
        .rst        (rst),
        .in_compare (state_r == ST_COMPARE),
        .hit_vec    (hit_vec),
        .valid_vec  (valid_vec),
        .lru_way    (lru_way)
    );
endmodule

// File: tb/tb_l2_cache_control.sv
// Directed testbench for l2_cache_control: an 8-way instance for the main
// scenarios and a 4-way instance for counter saturation and port width.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_l2_cache_control;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, pmem_resp;
    logic [7:0]  hit_vec, valid_vec, dirty_vec, lru_way;
    logic        mem_resp, lru_load, data_load, data_src, tag_load;
    logic        valid_set, dirty_set, dirty_clr, pmem_read, pmem_write, pmem_addr_sel;
    logic [7:0]  lru_hit_way, way_sel;
    logic [31:0] hit_count, miss_count;

    logic        mem_read_4, mem_write_4, pmem_resp_4;
    logic [3:0]  hit_vec_4, valid_vec_4, dirty_vec_4, lru_way_4;
    logic        mem_resp_4, lru_load_4, data_load_4, data_src_4, tag_load_4;
    logic        valid_set_4, dirty_set_4, dirty_clr_4, pmem_read_4, pmem_write_4, pmem_addr_sel_4;
    logic [3:0]  lru_hit_way_4, way_sel_4;
    logic [31:0] hit_count_4, miss_count_4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    l2_cache_control #(.num_ways(8)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit_vec(hit_vec), .valid_vec(valid_vec), .dirty_vec(dirty_vec), .lru_way(lru_way),
        .lru_load(lru_load), .lru_hit_way(lru_hit_way), .way_sel(way_sel),
        .data_load(data_load), .data_src(data_src), .tag_load(tag_load), .valid_set(valid_set),
        .dirty_set(dirty_set), .dirty_clr(dirty_clr), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_addr_sel(pmem_addr_sel), .pmem_resp(pmem_resp),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    l2_cache_control #(.num_ways(4)) dut4 (
        .clk(clk), .rst(rst), .mem_read(mem_read_4), .mem_write(mem_write_4), .mem_resp(mem_resp_4),
        .hit_vec(hit_vec_4), .valid_vec(valid_vec_4), .dirty_vec(dirty_vec_4), .lru_way(lru_way_4),
        .lru_load(lru_load_4), .lru_hit_way(lru_hit_way_4), .way_sel(way_sel_4),
        .data_load(data_load_4), .data_src(data_src_4), .tag_load(tag_load_4), .valid_set(valid_set_4),
        .dirty_set(dirty_set_4), .dirty_clr(dirty_clr_4), .pmem_read(pmem_read_4),
        .pmem_write(pmem_write_4), .pmem_addr_sel(pmem_addr_sel_4), .pmem_resp(pmem_resp_4),
        .hit_count(hit_count_4), .miss_count(miss_count_4)
    );

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit_vec = 8'h00; valid_vec = 8'h00; dirty_vec = 8'h00; lru_way = 8'h01;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mem_read_4 = 1'b0; mem_write_4 = 1'b0; pmem_resp_4 = 1'b0;
        hit_vec_4 = 4'h0; valid_vec_4 = 4'hF; dirty_vec_4 = 4'h0; lru_way_4 = 4'h1;
        do_reset();
        rst = 1'b0;
        #1;
        check_vec("rst_mem_resp", {31'd0, mem_resp}, 32'd0);
        check_vec("rst_pmem", {30'd0, pmem_read, pmem_write}, 32'd0);
        check_vec("rst_hit_count", hit_count, 32'd0);
        check_vec("rst_miss_count", miss_count, 32'd0);
        rst = 1'b1;

        // Read hit on way 2.
        nxt();
        valid_vec = 8'hFF; hit_vec = 8'h04; mem_read = 1'b1;
        #1;
        check_vec("rh_idle_resp", {31'd0, mem_resp}, 32'd0);
        nxt();
        check_vec("rh_resp", {31'd0, mem_resp}, 32'd1);
        check_vec("rh_lru_load", {31'd0, lru_load}, 32'd1);
        check_vec("rh_lru_hit_way", {24'd0, lru_hit_way}, 32'h04);
        check_vec("rh_way_sel", {24'd0, way_sel}, 32'h04);
        check_vec("rh_data_load", {31'd0, data_load}, 32'd0);
        check_vec("rh_pmem", {30'd0, pmem_read, pmem_write}, 32'd0);
        mem_read = 1'b0;
        nxt();
        hit_vec = 8'h00;
        #1;
        check_vec("rh_resp_drop", {31'd0, mem_resp}, 32'd0);
        check_vec("rh_lru_drop", {31'd0, lru_load}, 32'd0);
        check_vec("rh_hit_count", hit_count, 32'd1);

        // Write hit on way 7.
        mem_write = 1'b1; hit_vec = 8'h80;
        nxt();
        check_vec("wh_resp", {31'd0, mem_resp}, 32'd1);
        check_vec("wh_data_load", {31'd0, data_load}, 32'd1);
        check_vec("wh_data_src", {31'd0, data_src}, 32'd0);
        check_vec("wh_dirty_set", {31'd0, dirty_set}, 32'd1);
        check_vec("wh_way_sel", {24'd0, way_sel}, 32'h80);
        check_vec("wh_tag_load", {31'd0, tag_load}, 32'd0);
        mem_write = 1'b0;
        nxt();
        hit_vec = 8'h00;
        check_vec("wh_hit_count", hit_count, 32'd2);
        check_vec("wh_miss_count", miss_count, 32'd0);

        // Clean miss: way 3 is invalid, so it wins over lru_way.
        do_reset();
        nxt();
        valid_vec = 8'hF7; hit_vec = 8'h00; lru_way = 8'h01; mem_read = 1'b1;
        nxt();
        check_vec("cm_cmp_resp", {31'd0, mem_resp}, 32'd0);
        check_vec("cm_cmp_lru_load", {31'd0, lru_load}, 32'd0);
        check_vec("cm_cmp_pmem", {31'd0, pmem_read}, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            nxt();
            check_vec("cm_fill_pmem_read", {31'd0, pmem_read}, 32'd1);
            check_vec("cm_fill_way_sel", {24'd0, way_sel}, 32'h08);
            check_vec("cm_fill_addr_sel", {31'd0, pmem_addr_sel}, 32'd0);
            check_vec("cm_fill_pmem_write", {31'd0, pmem_write}, 32'd0);
            if (c == 5) begin
                pmem_resp = 1'b1;
                #1;
                check_vec("cm_fill_strobes", {27'd0, data_load, data_src, tag_load, valid_set, dirty_clr}, 32'h1F);
            end else begin
                check_vec("cm_fill_wait_load", {31'd0, data_load}, 32'd0);
            end
        end
        nxt();
        pmem_resp = 1'b0; hit_vec = 8'h08; valid_vec = 8'hFF;
        #1;
        check_vec("cm_re_resp", {31'd0, mem_resp}, 32'd1);
        check_vec("cm_re_lru_hit_way", {24'd0, lru_hit_way}, 32'h08);
        check_vec("cm_re_pmem", {30'd0, pmem_read, pmem_write}, 32'd0);
        check_vec("cm_re_no_merge", {31'd0, data_load}, 32'd0);
        mem_read = 1'b0;
        nxt();
        hit_vec = 8'h00;
        check_vec("cm_miss_count", miss_count, 32'd1);
        check_vec("cm_hit_count", hit_count, 32'd1);

        // Dirty miss: full set, LRU victim way 5 is dirty.
        do_reset();
        nxt();
        valid_vec = 8'hFF; dirty_vec = 8'h20; lru_way = 8'h20; hit_vec = 8'h00; mem_write = 1'b1;
        nxt();
        check_vec("dm_cmp_resp", {31'd0, mem_resp}, 32'd0);
        for (int c = 1; c <= 3; c++) begin
            nxt();
            check_vec("dm_wb_pmem", {30'd0, pmem_read, pmem_write}, 32'd1);
            check_vec("dm_wb_addr_sel", {31'd0, pmem_addr_sel}, 32'd1);
            check_vec("dm_wb_way_sel", {24'd0, way_sel}, 32'h20);
            if (c == 3) begin
                pmem_resp = 1'b1;
                #1;
                check_vec("dm_wb_resp_no_load", {31'd0, data_load}, 32'd0);
            end else begin
                check_vec("dm_wb_wait_resp", {31'd0, mem_resp}, 32'd0);
            end
        end
        for (int c = 1; c <= 2; c++) begin
            nxt();
            pmem_resp = 1'b0;
            #1;
            check_vec("dm_fill_pmem", {30'd0, pmem_read, pmem_write}, 32'd2);
            check_vec("dm_fill_addr_sel", {31'd0, pmem_addr_sel}, 32'd0);
            check_vec("dm_fill_way_sel", {24'd0, way_sel}, 32'h20);
            if (c == 2) begin
                pmem_resp = 1'b1;
                #1;
                check_vec("dm_fill_strobes", {27'd0, data_load, data_src, tag_load, valid_set, dirty_clr}, 32'h1F);
            end else begin
                check_vec("dm_fill_wait_load", {31'd0, tag_load}, 32'd0);
            end
        end
        nxt();
        pmem_resp = 1'b0; hit_vec = 8'h20; dirty_vec = 8'h00;
        #1;
        check_vec("dm_re_resp", {31'd0, mem_resp}, 32'd1);
        check_vec("dm_re_merge", {29'd0, data_load, data_src, dirty_set}, 32'h5);
        mem_write = 1'b0;
        nxt();
        hit_vec = 8'h00;
        check_vec("dm_miss_count", miss_count, 32'd1);
        check_vec("dm_hit_count", hit_count, 32'd1);

        // Reset in the middle of a fill.
        do_reset();
        nxt();
        valid_vec = 8'hF7; hit_vec = 8'h00; mem_read = 1'b1;
        nxt();
        nxt();
        check_vec("rf_fill_active", {31'd0, pmem_read}, 32'd1);
        rst = 1'b0;
        #1;
        check_vec("rf_async_drop", {31'd0, pmem_read}, 32'd0);
        check_vec("rf_miss_cleared", miss_count, 32'd0);
        mem_read = 1'b0;
        nxt();
        rst = 1'b1;
        nxt();
        pmem_resp = 1'b1;
        #1;
        check_vec("rf_stray_resp", {28'd0, pmem_read, pmem_write, data_load, tag_load}, 32'd0);
        nxt();
        pmem_resp = 1'b0;
        #1;
        check_vec("rf_stray_idle", {30'd0, pmem_read, mem_resp}, 32'd0);
        valid_vec = 8'hFF; hit_vec = 8'h04; mem_read = 1'b1;
        nxt();
        check_vec("rf_post_hit_resp", {31'd0, mem_resp}, 32'd1);
        mem_read = 1'b0;
        nxt();
        hit_vec = 8'h00;
        check_vec("rf_post_hit_count", hit_count, 32'd1);

        // Read and write both high is treated as a write.
        mem_read = 1'b1; mem_write = 1'b1; hit_vec = 8'h02;
        nxt();
        check_vec("rw_write_merge", {30'd0, data_load, dirty_set}, 32'h3);
        mem_read = 1'b0; mem_write = 1'b0;
        nxt();
        hit_vec = 8'h00;

        // 4-way instance: hit counter saturates.
        force dut4.hit_cnt_r = 32'hFFFF_FFFF;
        nxt();
        release dut4.hit_cnt_r;
        nxt();
        check_vec("sat_preload", hit_count_4, 32'hFFFF_FFFF);
        mem_read_4 = 1'b1; hit_vec_4 = 4'h2;
        nxt();
        check_vec("sat_resp", {31'd0, mem_resp_4}, 32'd1);
        check_vec("sat_lru_hit_way", {28'd0, lru_hit_way_4}, 32'h2);
        mem_read_4 = 1'b0;
        nxt();
        hit_vec_4 = 4'h0;
        check_vec("sat_hold", hit_count_4, 32'hFFFF_FFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
